// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit and the control FSM that drives it.
package mdu_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int ITER_DEF  = WIDTH_DEF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MULT   = 3'd1,
      ST_DIV    = 3'd2,
      ST_FINISH = 3'd3,
      ST_DZERO  = 3'd4
   } mdu_state_t;

   // R-type funct codes decoded by the control FSM.
   localparam logic [5:0] FUNCT_MULT = 6'b011000;
   localparam logic [5:0] FUNCT_DIV  = 6'b011010;

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider datapath on unsigned magnitudes; one quotient bit per step.
module div_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // Quotient register doubles as the dividend shift register.
   assign shifted = {remainder, quotient[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr};

   always_ff @(posedge clk) begin
      if (reset) begin
         dvsr      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (load) begin
         dvsr      <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (step) begin
         if (!diff[WIDTH]) begin
            remainder <= diff[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= shifted[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit feeding HI/LO.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mult_start,
   input  logic             div_start,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   mdu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             op_div;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] mcand;

   // Accumulator {P, Q, q-1}; P carries one guard bit so that subtracting the
   // most negative multiplicand cannot overflow.
   logic [2*WIDTH+1:0] acc;
   logic [2*WIDTH+1:0] booth_next;
   logic [WIDTH:0]     p_cur;
   logic [WIDTH:0]     p_sum;
   logic [WIDTH:0]     m_ext;

   logic             div_load;
   logic             div_step;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] quo_mag;
   logic [WIDTH-1:0] rem_mag;

   assign m_ext = {mcand[WIDTH-1], mcand};
   assign p_cur = acc[2*WIDTH+1:WIDTH+1];

   // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      p_sum = p_cur;
      unique case (acc[1:0])
         2'b01:   p_sum = p_cur + m_ext;
         2'b10:   p_sum = p_cur - m_ext;
         default: p_sum = p_cur;
      endcase
      booth_next = {p_sum[WIDTH], p_sum, acc[WIDTH:1]};
   end

   assign a_mag    = a[WIDTH-1] ? -a : a;
   assign b_mag    = b[WIDTH-1] ? -b : b;
   assign div_load = (state == ST_IDLE) && !mult_start && div_start && (b != '0);
   assign div_step = (state == ST_DIV);

   div_iter_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .step      (div_step),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quo_mag),
      .remainder (rem_mag)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         div0   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         op_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         mcand  <= '0;
         acc    <= '0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (mult_start) begin
                  state  <= ST_MULT;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  op_div <= 1'b0;
                  mcand  <= a;
                  acc    <= {{(WIDTH+1){1'b0}}, b, 1'b0};
               end else if (div_start) begin
                  if (b != '0) begin
                     state  <= ST_DIV;
                     busy   <= 1'b1;
                     cnt    <= '0;
                     op_div <= 1'b1;
                     neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                     neg_r  <= a[WIDTH-1];
                  end else begin
                     state <= ST_DZERO;
                  end
               end
            end
            ST_MULT: begin
               acc <= booth_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) state <= ST_FINISH;
            end
            ST_DIV: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) state <= ST_FINISH;
            end
            ST_FINISH: begin
               if (op_div) begin
                  hi <= neg_r ? -rem_mag : rem_mag;
                  lo <= neg_q ? -quo_mag : quo_mag;
               end else begin
                  hi <= acc[2*WIDTH:WIDTH+1];
                  lo <= acc[WIDTH:1];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_DZERO: begin
               div0  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic        mult_start;
   logic        div_start;
   logic        busy;
   logic        done;
   logic        div0;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .a          (a),
      .b          (b),
      .mult_start (mult_start),
      .div_start  (div_start),
      .busy       (busy),
      .done       (done),
      .div0       (div0),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a start pulse sampled at edge E0, then scramble the operands.
   task automatic start_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      a          = av;
      b          = bv;
      mult_start = m;
      div_start  = d;
      @(posedge clk);
      #1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      a          = 32'hDEAD_BEEF;
      b          = 32'h0BAD_F00D;
   endtask

   // Full operation with latency and one-cycle done checks.
   task automatic run_op(input string tag, input logic m, input logic d,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo);
      start_op(m, d, av, bv);
      check({tag, " busy@E0"}, 64'(busy), 64'd1);
      repeat (32) @(posedge clk);
      #1;
      check({tag, " done@E32"}, {62'd0, busy, done}, 64'd2);
      @(posedge clk);
      #1;
      check({tag, " done@E33"}, {62'd0, busy, done}, 64'd1);
      check({tag, " hi:lo"}, {hi, lo}, {ehi, elo});
      @(posedge clk);
      #1;
      check({tag, " done drop"}, 64'(done), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic seen_done;
      reset      = 1'b1;
      a          = '0;
      b          = '0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset state", {61'd0, busy, done, div0}, 64'd0);
      check("reset hi:lo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mul min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("mul -1*-1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
      run_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      check("min/-1 no div0", 64'(div0), 64'd0);
      run_op("both starts", 1'b1, 1'b1, 32'd6, 32'd7, 32'h0, 32'd42);

      // Preload hi/lo with 0x12/0x34 through 0x692 / 0x20.
      run_op("preload", 1'b0, 1'b1, 32'h692, 32'h20, 32'h12, 32'h34);
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      check("dz busy@E0", {62'd0, busy, div0}, 64'd0);
      @(posedge clk);
      #1;
      check("dz flags@E1", {61'd0, busy, done, div0}, 64'd1);
      @(posedge clk);
      #1;
      check("dz flags@E2", {61'd0, busy, done, div0}, 64'd0);
      check("dz hi:lo kept", {hi, lo}, {32'h12, 32'h34});

      // Abort: ignored div_start at E0+10, reset sampled at E0+12.
      start_op(1'b1, 1'b0, 32'h1234, 32'h5678);
      repeat (9) @(posedge clk);
      @(negedge clk);
      b         = 32'd3;
      div_start = 1'b1;
      @(posedge clk);
      #1;
      div_start = 1'b0;
      check("busy ignores start", 64'(busy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort flags", {61'd0, busy, done, div0}, 64'd0);
      check("abort hi:lo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset     = 1'b0;
      seen_done = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done = 1'b1;
      end
      check("no done after abort", 64'(seen_done), 64'd0);

      run_op("mul 3*4", 1'b1, 1'b0, 32'd3, 32'd4, 32'h0, 32'd12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
